// File: rtl/vram_pkg.sv
// Shared VRAM types: address/data widths and read-port identifiers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 16;

  typedef enum logic {
    PORT_DISPLAY = 1'b0,
    PORT_CPU     = 1'b1
  } port_id_t;

  // One in-flight read: whether a read was issued and which client owns it.
  typedef struct packed {
    logic     vld;
    port_id_t port;
  } rd_tag_t;

  localparam rd_tag_t TAG_NONE = '{vld: 1'b0, port: PORT_DISPLAY};

endpackage

// File: rtl/vram_read_tracker.sv
// Tag shift register that follows each VRAM read from grant to data return.
// Latency: DEPTH cycles from push_tag to pop_tag.
// Backpressure: none; a tag (valid or empty) is pushed and popped every cycle.
module vram_read_tracker
  import vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t push_tag,
  output rd_tag_t pop_tag
);

  rd_tag_t [DEPTH-1:0] tags_q;

  // Shift tags one stage per cycle; reset discards every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      tags_q <= {DEPTH{TAG_NONE}};
    end else begin
      tags_q <= {tags_q[DEPTH-2:0], push_tag};
    end
  end

  assign pop_tag = tags_q[DEPTH-1];

endmodule

// File: rtl/vram_read_arbiter.sv
// Arbitrates the single VRAM read port between display (port 0) and CPU (port 1).
// Latency: grant in N, raddr in N+1, validX/rdataX in N+2+READ_LATENCY.
// Backpressure: combinational gnt per request; port 0 priority, port 1 forced after MAX_WAIT denials.
module vram_read_arbiter
  import vram_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vram_loaded,
  output logic [VRAM_ADDR_W-1:0] vram_raddr,
  input  logic [VRAM_DATA_W-1:0] vram_rdata,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [VRAM_ADDR_W-1:0] addr0,
  input  logic [VRAM_ADDR_W-1:0] addr1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   valid0,
  output logic                   valid1,
  output logic [VRAM_DATA_W-1:0] rdata0,
  output logic [VRAM_DATA_W-1:0] rdata1
);

  logic                   eligible;
  logic                   force_cpu;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic [VRAM_ADDR_W-1:0] raddr_q, raddr_d;
  logic                   valid0_q, valid0_d;
  logic                   valid1_q, valid1_d;
  logic [VRAM_DATA_W-1:0] rdata0_q, rdata0_d;
  logic [VRAM_DATA_W-1:0] rdata1_q, rdata1_d;
  rd_tag_t                push_tag;
  rd_tag_t                pop_tag;

  assign eligible  = vram_loaded & ~reset;
  assign force_cpu = req1 & (wait_cnt_q == 8'(MAX_WAIT));

  // Grant selection: port 0 by default, port 1 when alone or when its wait hits the limit.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (eligible) begin
      if (req1 && (force_cpu || !req0)) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end
    end
  end

  // Starvation count, address latch and tag for the read issued this cycle.
  always_comb begin
    wait_cnt_d = wait_cnt_q + 8'd1;
    if (!req1 || gnt1) begin
      wait_cnt_d = 8'd0;
    end

    raddr_d = raddr_q;
    if (gnt1) begin
      raddr_d = addr1;
    end else if (gnt0) begin
      raddr_d = addr0;
    end

    push_tag      = TAG_NONE;
    push_tag.vld  = gnt0 | gnt1;
    push_tag.port = gnt1 ? PORT_CPU : PORT_DISPLAY;
  end

  // Return routing: the tag leaving the tracker lines up with vram_rdata this cycle.
  always_comb begin
    valid0_d = pop_tag.vld & (pop_tag.port == PORT_DISPLAY);
    valid1_d = pop_tag.vld & (pop_tag.port == PORT_CPU);
    rdata0_d = valid0_d ? vram_rdata : rdata0_q;
    rdata1_d = valid1_d ? vram_rdata : rdata1_q;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 8'd0;
      raddr_q    <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      raddr_q    <= raddr_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Depth covers the raddr register stage plus the VRAM read latency.
  vram_read_tracker #(
    .DEPTH(READ_LATENCY + 1)
  ) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .push_tag(push_tag),
    .pop_tag (pop_tag)
  );

  assign vram_raddr = raddr_q;
  assign valid0     = valid0_q;
  assign valid1     = valid1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;

endmodule
